// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug data-memory dump path:
// FSM state encoding, bytes per word and the default read latency.
package cpu_dbg_pkg;

    localparam int DUMP_BYTES = 4;
    localparam int WORD_W     = DUMP_BYTES * 8;
    localparam int DEF_RD_LAT = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SEND    = 3'd3,
        ST_NEXT    = 3'd4
    } dump_state_t;

endpackage

// File: rtl/dump_byte_ser.sv
// Word-to-byte serializer: loads one 32-bit word and presents it MSB byte
// first on a valid/ready byte interface.
//
// Handshake: a byte transfers on every rising edge where tx_valid and
// tx_ready are both high. Once tx_valid is raised, tx_valid and tx_data
// hold steady until that transfer happens; only clear (abort) or reset may
// drop tx_valid early. tx_valid never depends on tx_ready.
module dump_byte_ser
    import cpu_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [WORD_W-1:0] word,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              word_sent
);

    logic [WORD_W-1:0] shift_q;
    logic [1:0]        byte_idx;
    logic              fire;

    assign fire      = tx_valid & tx_ready;
    assign tx_data   = shift_q[WORD_W-1 -: 8];
    assign word_sent = fire && (byte_idx == 2'(DUMP_BYTES - 1));

    // Shift register, byte index and valid flag; clear beats a concurrent transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q  <= '0;
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (clear) begin
            byte_idx <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            shift_q  <= word;
            byte_idx <= '0;
            tx_valid <= 1'b1;
        end else if (fire) begin
            shift_q  <= {shift_q[WORD_W-9:0], 8'h00};
            byte_idx <= byte_idx + 2'd1;
            if (word_sent) begin
                tx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_dump_ctrl.sv
// Dumps an inclusive window of CPU data memory through the debug read port
// and streams every word as four bytes, MSB first, to a byte sink.
// DATA_W must stay 32: the serializer is built for four bytes per word.
module dmem_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = DEF_RD_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] dladdr,
    output logic              reading,
    input  logic [DATA_W-1:0] data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

    dump_state_t       state;
    logic [ADDR_W-1:0] last_q;
    logic [2:0]        lat_cnt;
    logic              ser_load;
    logic              ser_clear;
    logic              word_sent;

    assign ser_load  = (state == ST_CAPTURE);
    assign ser_clear = abort && (state != ST_IDLE);
    assign dbg_state = state;

    dump_byte_ser u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ser_load),
        .clear     (ser_clear),
        .word      (data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .word_sent (word_sent)
    );

    // Dump sequencer: address sweep, latency wait, word accounting; abort wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_q   <= '0;
            lat_cnt  <= '0;
            dladdr   <= '0;
            reading  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            word_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (ser_clear) begin
                // A final byte transferring alongside abort still completes its word.
                state   <= ST_IDLE;
                reading <= 1'b0;
                busy    <= 1'b0;
                if (word_sent) begin
                    word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            last_q   <= last_addr;
                            dladdr   <= base_addr;
                            reading  <= 1'b1;
                            busy     <= 1'b1;
                            word_cnt <= '0;
                            lat_cnt  <= '0;
                            state    <= ST_SETTLE;
                        end
                    end
                    ST_SETTLE: begin
                        if (lat_cnt == LAT_LAST) begin
                            state <= ST_CAPTURE;
                        end else begin
                            lat_cnt <= lat_cnt + 3'd1;
                        end
                    end
                    ST_CAPTURE: begin
                        state <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (word_sent) begin
                            word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
                            state    <= ST_NEXT;
                        end
                    end
                    ST_NEXT: begin
                        if (dladdr == last_q) begin
                            reading <= 1'b0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            dladdr  <= dladdr + {{(ADDR_W-1){1'b0}}, 1'b1};
                            lat_cnt <= '0;
                            state   <= ST_SETTLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Directed bench for dmem_dump_ctrl: one RD_LAT=1 instance for the
// functional scenarios and one RD_LAT=3 instance for the full-window sweep.
module tb_dmem_dump_ctrl;
    import cpu_dbg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // ---------------- DUT (RD_LAT=1) ----------------
    logic       start, abort, tx_ready;
    logic [7:0] base_addr, last_addr, dladdr, tx_data;
    logic       reading, tx_valid, busy, done;
    logic [31:0] data;
    logic [8:0] word_cnt;
    logic [2:0] dbg_state;

    dmem_dump_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .base_addr(base_addr), .last_addr(last_addr), .dladdr(dladdr),
        .reading(reading), .data(data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .word_cnt(word_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- DUT (RD_LAT=3) ----------------
    logic       start_3, abort_3, tx_ready_3;
    logic [7:0] base_addr_3, last_addr_3, dladdr_3, tx_data_3;
    logic       reading_3, tx_valid_3, busy_3, done_3;
    logic [31:0] data_3;
    logic [8:0] word_cnt_3;
    logic [2:0] dbg_state_3;

    dmem_dump_ctrl #(.ADDR_W(8), .DATA_W(32), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start_3), .abort(abort_3),
        .base_addr(base_addr_3), .last_addr(last_addr_3), .dladdr(dladdr_3),
        .reading(reading_3), .data(data_3), .tx_data(tx_data_3), .tx_valid(tx_valid_3),
        .tx_ready(tx_ready_3), .busy(busy_3), .done(done_3), .word_cnt(word_cnt_3),
        .dbg_state(dbg_state_3)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem [256];
    logic [31:0] rd1, p0, p1, p2;

    always @(posedge clk) rd1 <= mem[dladdr];
    assign data = rd1;

    always @(posedge clk) begin
        p0 <= mem[dladdr_3];
        p1 <= p0;
        p2 <= p1;
    end
    assign data_3 = p2;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_q3[$];
    logic [7:0] addr_log[$];
    bit   mon_en  = 1'b1;
    bit   mon3_en = 1'b0;
    logic [7:0] mon_exp, mon_exp3;
    int   byte3_cnt = 0;
    int   cyc3 = 0;

    logic       prev_stall = 1'b0;
    logic       prev_abort = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] prev_dladdr = 8'h00;
    logic [2:0] prev_state = 3'd0;
    logic [2:0] prev_state3 = 3'd0;

    task automatic push_word(input logic [31:0] w, input bit to3);
        if (to3) begin
            exp_q3.push_back(w[31:24]); exp_q3.push_back(w[23:16]);
            exp_q3.push_back(w[15:8]);  exp_q3.push_back(w[7:0]);
        end else begin
            exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
        end
    endtask

    // Byte stream, stall-hold and address-stability monitor for the RD_LAT=1 DUT.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte unexpected got=%h exp=none", tx_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (tx_data !== mon_exp) begin
                        errors++;
                        $display("FAIL tx_byte got=%h exp=%h", tx_data, mon_exp);
                    end
                end
            end
            if (prev_stall && !prev_abort) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b data=%h exp valid=1 data=%h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (prev_state == ST_SETTLE || prev_state == ST_CAPTURE || prev_state == ST_SEND) begin
                checks++;
                if (dladdr !== prev_dladdr) begin
                    errors++;
                    $display("FAIL dladdr_stable got=%h exp=%h", dladdr, prev_dladdr);
                end
            end
            if (dbg_state != ST_IDLE) begin
                checks++;
                if (reading !== 1'b1) begin
                    errors++;
                    $display("FAIL reading_high got=%b exp=1 state=%0d", reading, dbg_state);
                end
            end
        end
        prev_stall  = tx_valid && !tx_ready;
        prev_abort  = abort;
        prev_data   = tx_data;
        prev_dladdr = dladdr;
        prev_state  = dbg_state;
    end

    // Byte stream and capture-latency monitor for the RD_LAT=3 DUT.
    always @(negedge clk) begin
        if (rst_n && mon3_en) begin
            if (tx_valid_3 && tx_ready_3) begin
                byte3_cnt++;
                checks++;
                if (exp_q3.size() == 0) begin
                    errors++;
                    $display("FAIL tx_byte3 unexpected got=%h exp=none", tx_data_3);
                end else begin
                    mon_exp3 = exp_q3.pop_front();
                    if (tx_data_3 !== mon_exp3) begin
                        errors++;
                        $display("FAIL tx_byte3 got=%h exp=%h", tx_data_3, mon_exp3);
                    end
                end
            end
            if (dbg_state_3 == ST_SETTLE && prev_state3 != ST_SETTLE) cyc3 = 0;
            else cyc3++;
            if (dbg_state_3 == ST_CAPTURE && prev_state3 != ST_CAPTURE) begin
                checks++;
                if (cyc3 != 3) begin
                    errors++;
                    $display("FAIL capture_lat3 got=%0d exp=3 addr=%h", cyc3, dladdr_3);
                end
            end
        end
        prev_state3 = dbg_state_3;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a dump on the RD_LAT=1 DUT and runs it to IDLE.
    // mode 0: tx_ready high; mode 1: ready 1 cycle on, 2 off.
    // poke: loop cycle at which a stray start (base=last=0x80) is pulsed.
    task automatic run_dump(input logic [7:0] b, input logic [7:0] l, input int mode,
                            input int poke, input int budget,
                            output int n_done, output int done_at);
        int k;
        bit fin;
        n_done = 0;
        done_at = -1;
        addr_log.delete();
        base_addr = b;
        last_addr = l;
        tx_ready  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got=%b exp=1", busy);
        end
        k = 0;
        fin = 1'b0;
        while (!fin && k < budget) begin
            k++;
            tx_ready = (mode == 1) ? ((k % 3) == 1) : 1'b1;
            if (k == poke) begin
                start = 1'b1; base_addr = 8'h80; last_addr = 8'h80;
            end else if (k == poke + 1) begin
                start = 1'b0; base_addr = b; last_addr = l;
            end
            tick();
            if (dbg_state == ST_CAPTURE) addr_log.push_back(dladdr);
            if (done) begin
                n_done++;
                done_at = k;
                checks++;
                if (reading !== 1'b0) begin
                    errors++;
                    $display("FAIL reading_with_done got=%b exp=0", reading);
                end
            end
            if (!busy) fin = 1'b1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL dump_timeout got=busy exp=idle within %0d cycles", budget);
        end
        start = 1'b0;
        tx_ready = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({dladdr, reading, tx_data, tx_valid, busy, done, word_cnt, dbg_state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h/%b/%h/%b/%b/%b/%h/%h exp=all zero",
                     dladdr, reading, tx_data, tx_valid, busy, done, word_cnt, dbg_state);
        end
        checks++;
        if ({dladdr_3, reading_3, tx_valid_3, busy_3, word_cnt_3} !== '0) begin
            errors++;
            $display("FAIL reset_outputs3 got=%h/%b/%b/%b/%h exp=all zero",
                     dladdr_3, reading_3, tx_valid_3, busy_3, word_cnt_3);
        end
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got state=%0d busy=%b exp state=0 busy=0", dbg_state, busy);
        end
    endtask

    task automatic test_basic();
        int nd, da;
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
        exp_q.push_back(8'hA5); exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'h5A);
        exp_q.push_back(8'hDE); exp_q.push_back(8'hAD); exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        run_dump(8'h10, 8'h12, 0, 0, 100, nd, da);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL basic_bytes_left got=%0d exp=0", exp_q.size()); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", nd); end
        checks++;
        if (word_cnt !== 9'd3) begin errors++; $display("FAIL basic_word_cnt got=%0d exp=3", word_cnt); end
        checks++;
        if (da != 21) begin errors++; $display("FAIL basic_throughput got=%0d exp=21", da); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    endtask

    task automatic test_backpressure();
        int nd, da;
        push_word(32'h11223344, 1'b0);
        push_word(32'hA5A55A5A, 1'b0);
        push_word(32'hDEADBEEF, 1'b0);
        run_dump(8'h10, 8'h12, 1, 0, 200, nd, da);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_bytes_left got=%0d exp=0", exp_q.size()); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", nd); end
        checks++;
        if (word_cnt !== 9'd3) begin errors++; $display("FAIL bp_word_cnt got=%0d exp=3", word_cnt); end
    endtask

    task automatic test_wrap();
        int nd, da;
        logic [7:0] ea [4];
        ea[0] = 8'hFE; ea[1] = 8'hFF; ea[2] = 8'h00; ea[3] = 8'h01;
        for (int i = 0; i < 4; i++) push_word(mem[ea[i]], 1'b0);
        run_dump(8'hFE, 8'h01, 0, 0, 100, nd, da);
        checks++;
        if (addr_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_addr_count got=%0d exp=4", addr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addr_log[i] !== ea[i]) begin
                    errors++;
                    $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addr_log[i], ea[i]);
                end
            end
        end
        checks++;
        if (word_cnt !== 9'd4) begin errors++; $display("FAIL wrap_word_cnt got=%0d exp=4", word_cnt); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_bytes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_single_word();
        int nd, da;
        push_word(mem[0], 1'b0);
        run_dump(8'h00, 8'h00, 0, 0, 50, nd, da);
        checks++;
        if (word_cnt !== 9'd1) begin errors++; $display("FAIL single_word_cnt got=%0d exp=1", word_cnt); end
        checks++;
        if (da != 7) begin errors++; $display("FAIL single_done_at got=%0d exp=7", da); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL single_bytes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_abort();
        int nd, da;
        logic [31:0] w1;
        // start together with abort in IDLE: stays idle
        base_addr = 8'h00; last_addr = 8'h05;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || busy !== 1'b0 || reading !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle got state=%0d busy=%b reading=%b exp 0/0/0",
                     dbg_state, busy, reading);
        end
        // abort during byte 2 of word 1; that byte handshakes with abort
        w1 = mem[1];
        push_word(mem[0], 1'b0);
        exp_q.push_back(w1[31:24]); exp_q.push_back(w1[23:16]); exp_q.push_back(w1[15:8]);
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        checks++;
        if (dbg_state !== ST_SEND || dladdr !== 8'h01 || tx_data !== w1[15:8]) begin
            errors++;
            $display("FAIL abort_setup got state=%0d addr=%h data=%h exp state=3 addr=01 data=%h",
                     dbg_state, dladdr, tx_data, w1[15:8]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (dbg_state !== ST_IDLE || reading !== 1'b0 || tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_outputs got state=%0d rd=%b vld=%b busy=%b done=%b exp 0/0/0/0/0",
                     dbg_state, reading, tx_valid, busy, done);
        end
        checks++;
        if (word_cnt !== 9'd1) begin errors++; $display("FAIL abort_word_cnt got=%0d exp=1", word_cnt); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL abort_bytes_left got=%0d exp=0", exp_q.size()); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || word_cnt !== 9'd1) begin
                errors++;
                $display("FAIL abort_quiet got done=%b cnt=%0d exp done=0 cnt=1", done, word_cnt);
            end
        end
        // clean restart from base
        push_word(mem[0], 1'b0);
        push_word(mem[1], 1'b0);
        run_dump(8'h00, 8'h01, 0, 0, 100, nd, da);
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 8'h00 || addr_log[1] !== 8'h01) begin
            errors++;
            $display("FAIL restart_addrs got n=%0d exp n=2 addrs 00,01", addr_log.size());
        end
        checks++;
        if (word_cnt !== 9'd2 || nd != 1) begin
            errors++;
            $display("FAIL restart_result got cnt=%0d done=%0d exp cnt=2 done=1", word_cnt, nd);
        end
    endtask

    task automatic test_start_while_busy();
        int nd, da;
        push_word(mem[8'h20], 1'b0);
        push_word(mem[8'h21], 1'b0);
        run_dump(8'h20, 8'h21, 0, 5, 100, nd, da);
        checks++;
        if (addr_log.size() != 2 || addr_log[0] !== 8'h20 || addr_log[1] !== 8'h21) begin
            errors++;
            $display("FAIL busy_start_addrs got n=%0d exp n=2 addrs 20,21", addr_log.size());
        end
        checks++;
        if (word_cnt !== 9'd2) begin errors++; $display("FAIL busy_start_word_cnt got=%0d exp=2", word_cnt); end
        checks++;
        if (da != 14) begin errors++; $display("FAIL busy_start_done_at got=%0d exp=14", da); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL busy_start_bytes_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid_send();
        mon_en = 1'b0;
        base_addr = 8'h00; last_addr = 8'h03;
        tx_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        checks++;
        if (dbg_state !== ST_SEND || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup got state=%0d vld=%b exp state=3 vld=1", dbg_state, tx_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dladdr, reading, tx_data, tx_valid, busy, done, word_cnt, dbg_state} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs got=%h/%b/%h/%b/%b/%b/%h/%h exp=all zero",
                     dladdr, reading, tx_data, tx_valid, busy, done, word_cnt, dbg_state);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        exp_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic test_full_sweep_lat3();
        int k, nd, da;
        bit fin;
        for (int a = 0; a < 256; a++) push_word(mem[a], 1'b1);
        byte3_cnt = 0;
        mon3_en = 1'b1;
        base_addr_3 = 8'h00; last_addr_3 = 8'hFF; tx_ready_3 = 1'b1;
        start_3 = 1'b1;
        tick();
        start_3 = 1'b0;
        k = 0; nd = 0; da = -1; fin = 1'b0;
        while (!fin && k < 3000) begin
            k++;
            tick();
            if (done_3) begin nd++; da = k; end
            if (!busy_3) fin = 1'b1;
        end
        checks++;
        if (!fin) begin errors++; $display("FAIL sweep3_timeout got=busy exp=idle"); end
        checks++;
        if (byte3_cnt != 1024) begin errors++; $display("FAIL sweep3_bytes got=%0d exp=1024", byte3_cnt); end
        checks++;
        if (word_cnt_3 !== 9'd256) begin errors++; $display("FAIL sweep3_word_cnt got=%0d exp=256", word_cnt_3); end
        checks++;
        if (nd != 1 || da != 2304) begin
            errors++;
            $display("FAIL sweep3_done got count=%0d at=%0d exp count=1 at=2304", nd, da);
        end
        checks++;
        if (exp_q3.size() != 0) begin errors++; $display("FAIL sweep3_bytes_left got=%0d exp=0", exp_q3.size()); end
        mon3_en = 1'b0;
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; tx_ready = 1'b0; base_addr = '0; last_addr = '0;
        start_3 = 1'b0; abort_3 = 1'b0; tx_ready_3 = 1'b0; base_addr_3 = '0; last_addr_3 = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5A, 8'hC3};
        end
        mem[8'h10] = 32'h11223344;
        mem[8'h11] = 32'hA5A55A5A;
        mem[8'h12] = 32'hDEADBEEF;

        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_single_word();
        test_abort();
        test_start_while_busy();
        test_reset_mid_send();
        test_full_sweep_lat3();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
